// File: rtl/fp32_mul_handshake.sv
// rtl/fp32_mul_handshake.sv - IEEE-754 single-precision multiplier, a/b/z strobe-acknowledge responder
// Denormals flush to zero, round-to-nearest-even; one FSM step per clock.
module fp32_mul_handshake (
  input  logic        iClk,
  input  logic        iRstn,
  input  logic [31:0] data_a,
  input  logic        a_stb,
  output logic        a_ack,
  input  logic [31:0] data_b,
  input  logic        b_stb,
  output logic        b_ack,
  output logic [31:0] result,
  output logic        z_stb,
  input  logic        z_ack
);

  typedef enum logic [3:0] {
    GET_A, GET_B, UNPACK, SPECIAL, MULTIPLY, NORMALISE, ROUND, PACK, PUT_Z
  } state_t;

  state_t             state;
  logic [31:0]        a, b;
  logic               sign;
  logic signed [9:0]  ea, eb, ze;
  logic [23:0]        ma, mb, mant;
  logic [47:0]        p;
  logic               guard, round_bit, sticky;

  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [24:0] mant_inc;

  assign a_ack = (state == GET_A);
  assign b_ack = (state == GET_B);
  assign z_stb = (state == PUT_Z);

  // Classification straight from the latched operands; exp field 0 counts as zero.
  assign a_nan    = (&a[30:23]) && (|a[22:0]);
  assign b_nan    = (&b[30:23]) && (|b[22:0]);
  assign a_inf    = (&a[30:23]) && !(|a[22:0]);
  assign b_inf    = (&b[30:23]) && !(|b[22:0]);
  assign a_zero   = (a[30:23] == 8'd0);
  assign b_zero   = (b[30:23] == 8'd0);
  assign mant_inc = {1'b0, mant} + 25'd1;

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      state     <= GET_A;
      result    <= 32'd0;
      a         <= 32'd0;
      b         <= 32'd0;
      sign      <= 1'b0;
      ea        <= 10'sd0;
      eb        <= 10'sd0;
      ze        <= 10'sd0;
      ma        <= 24'd0;
      mb        <= 24'd0;
      mant      <= 24'd0;
      p         <= 48'd0;
      guard     <= 1'b0;
      round_bit <= 1'b0;
      sticky    <= 1'b0;
    end else begin
      case (state)
        GET_A: if (a_stb) begin
          a     <= data_a;
          state <= GET_B;
        end
        GET_B: if (b_stb) begin
          b     <= data_b;
          state <= UNPACK;
        end
        UNPACK: begin
          sign  <= a[31] ^ b[31];
          ea    <= $signed({2'b00, a[30:23]}) - 10'sd127;
          eb    <= $signed({2'b00, b[30:23]}) - 10'sd127;
          ma    <= a_zero ? 24'd0 : {1'b1, a[22:0]};
          mb    <= b_zero ? 24'd0 : {1'b1, b[22:0]};
          state <= SPECIAL;
        end
        SPECIAL: begin
          state <= PUT_Z;
          if (a_nan || b_nan)
            result <= 32'h7FC00000;
          else if ((a_inf && b_zero) || (b_inf && a_zero))
            result <= 32'h7FC00000;
          else if (a_inf || b_inf)
            result <= {sign, 8'hFF, 23'd0};
          else if (a_zero || b_zero)
            result <= {sign, 31'd0};
          else
            state <= MULTIPLY;
        end
        MULTIPLY: begin
          p     <= {24'd0, ma} * {24'd0, mb};
          ze    <= ea + eb;
          state <= NORMALISE;
        end
        NORMALISE: begin
          if (p[47]) begin
            mant      <= p[47:24];
            guard     <= p[23];
            round_bit <= p[22];
            sticky    <= |p[21:0];
            ze        <= ze + 10'sd1;
          end else begin
            mant      <= p[46:23];
            guard     <= p[22];
            round_bit <= p[21];
            sticky    <= |p[20:0];
          end
          state <= ROUND;
        end
        ROUND: begin
          if (guard && (round_bit || sticky || mant[0])) begin
            if (mant_inc[24]) begin
              mant <= 24'h800000;
              ze   <= ze + 10'sd1;
            end else begin
              mant <= mant_inc[23:0];
            end
          end
          state <= PACK;
        end
        PACK: begin
          // In-range ze fits in 8 bits two's complement, so biasing the low byte is exact.
          if (ze > 10'sd127)
            result <= {sign, 8'hFF, 23'd0};
          else if (ze < -10'sd126)
            result <= {sign, 31'd0};
          else
            result <= {sign, ze[7:0] + 8'd127, mant[22:0]};
          state <= PUT_Z;
        end
        PUT_Z: if (z_ack) state <= GET_A;
        default: state <= GET_A;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_mul_handshake.sv
// tb/tb_fp32_mul_handshake.sv - directed vector bench for fp32_mul_handshake
module tb_fp32_mul_handshake;

  logic        iClk = 1'b0;
  logic        iRstn = 1'b0;
  logic [31:0] data_a = '0, data_b = '0;
  logic        a_stb = 1'b0, b_stb = 1'b0, z_ack = 1'b0;
  logic        a_ack, b_ack, z_stb;
  logic [31:0] result;

  int checks = 0;
  int failures = 0;

  fp32_mul_handshake dut (
    .iClk(iClk), .iRstn(iRstn),
    .data_a(data_a), .a_stb(a_stb), .a_ack(a_ack),
    .data_b(data_b), .b_stb(b_stb), .b_ack(b_ack),
    .result(result), .z_stb(z_stb), .z_ack(z_ack)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] z;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic do_mul(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    int n;
    n = 0;
    while (!a_ack && n < 40) begin tick(); n++; end
    check("a_ack_ready", {31'd0, a_ack}, 32'd1);
    data_a = a; a_stb = 1'b1;
    tick();
    a_stb = 1'b0;
    n = 0;
    while (!b_ack && n < 40) begin tick(); n++; end
    data_b = b; b_stb = 1'b1;
    tick();
    b_stb = 1'b0;
    lat = 0;
    while (!z_stb && lat < 40) begin tick(); lat++; end
    res = result;
    z_ack = 1'b1;
    tick();
    z_ack = 1'b0;
    check("a_ack_after_zack", {31'd0, a_ack}, 32'd1);
    check("z_stb_after_zack", {31'd0, z_stb}, 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    int lat;
    int n;

    vecs[0]  = '{32'h40000000, 32'h40400000, 32'h40C00000, 6};
    vecs[1]  = '{32'h3FC00000, 32'hC0200000, 32'hC0700000, 6};
    vecs[2]  = '{32'h3F800001, 32'h3FC00000, 32'h3FC00002, 6};
    vecs[3]  = '{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 6};
    vecs[4]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 2};
    vecs[5]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 2};
    vecs[6]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 2};
    vecs[7]  = '{32'h80000000, 32'h40000000, 32'h80000000, 2};
    vecs[8]  = '{32'h7F000000, 32'h40000000, 32'h7F800000, 6};
    vecs[9]  = '{32'h00800000, 32'h3F000000, 32'h00000000, 6};
    vecs[10] = '{32'h00000001, 32'h40000000, 32'h00000000, 2};

    tick(); tick();
    check("rst_a_ack", {31'd0, a_ack}, 32'd1);
    check("rst_b_ack", {31'd0, b_ack}, 32'd0);
    check("rst_z_stb", {31'd0, z_stb}, 32'd0);
    check("rst_result", result, 32'd0);
    iRstn = 1'b1;
    tick();

    // b_stb while waiting for A must not advance the FSM
    data_b = 32'h12345678; b_stb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("b_stb_in_get_a_b_ack", {31'd0, b_ack}, 32'd0);
      check("b_stb_in_get_a_a_ack", {31'd0, a_ack}, 32'd1);
    end
    b_stb = 1'b0;

    for (int i = 0; i < 11; i++) begin
      do_mul(vecs[i].a, vecs[i].b, r, lat);
      check($sformatf("vec%0d_result", i), r, vecs[i].z);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
    end

    // Hold result through a long z_ack wait with a_stb asserted
    data_a = 32'h3FC00000; a_stb = 1'b1;
    tick();
    a_stb = 1'b0;
    data_b = 32'hC0200000; b_stb = 1'b1;
    tick();
    b_stb = 1'b0;
    n = 0;
    while (!z_stb && n < 40) begin tick(); n++; end
    data_a = 32'h40000000; a_stb = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("hold_z_stb", {31'd0, z_stb}, 32'd1);
      check("hold_result", result, 32'hC0700000);
      check("hold_a_ack", {31'd0, a_ack}, 32'd0);
      tick();
    end
    z_ack = 1'b1;
    tick();
    z_ack = 1'b0;
    check("post_hold_a_ack", {31'd0, a_ack}, 32'd1);
    check("post_hold_z_stb", {31'd0, z_stb}, 32'd0);
    tick();
    a_stb = 1'b0;
    check("held_a_taken_b_ack", {31'd0, b_ack}, 32'd1);
    data_b = 32'h40400000; b_stb = 1'b1;
    tick();
    b_stb = 1'b0;
    lat = 0;
    while (!z_stb && lat < 40) begin tick(); lat++; end
    check("held_a_latency", lat, 6);
    check("held_a_result", result, 32'h40C00000);
    z_ack = 1'b1;
    tick();
    z_ack = 1'b0;

    // Asynchronous reset while in MULTIPLY
    data_a = 32'h40000000; a_stb = 1'b1;
    tick();
    a_stb = 1'b0;
    data_b = 32'h40400000; b_stb = 1'b1;
    tick();
    b_stb = 1'b0;
    tick(); tick();
    iRstn = 1'b0;
    #1;
    check("midrst_a_ack", {31'd0, a_ack}, 32'd1);
    check("midrst_b_ack", {31'd0, b_ack}, 32'd0);
    check("midrst_z_stb", {31'd0, z_stb}, 32'd0);
    check("midrst_result", result, 32'd0);
    tick();
    iRstn = 1'b1;
    tick();
    do_mul(32'h40000000, 32'h40400000, r, lat);
    check("post_rst_result", r, 32'h40C00000);
    check("post_rst_latency", lat, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
